monitor_report_collector: RTL and testbench
===========================================

MONITOR_REPORT_COLLECTOR -- requirements
Module: monitor_report_collector

Interface
REQ-001 Parameters SHALL be: N_REPORTS, default 4, number of automaton report lines; TS_WIDTH, default 16, timestamp width; DEPTH, default 8, FIFO entries, power of two >= 2.
REQ-002 Reset and clock SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-003 clk  input  1  rising-edge clock shared with the automaton.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 run  input  1  symbol-valid strobe, same signal that drives the automaton STEs.
REQ-006 report_in  input  N_REPORTS  automaton report outputs (active_state of the report STEs), bit i = report node i.
REQ-007 report_mask  input  N_REPORTS  per-line enable; 1 = line may create events.
REQ-008 clear_stats  input  1  single-cycle pulse that clears the overflow count and the sticky flag.
REQ-009 out_valid  output  1  FIFO head holds an event.
REQ-010 out_ready  input  1  consumer accepts the head.
REQ-011 out_data  output  TS_WIDTH+N_REPORTS  {timestamp, masked report vector}, with the vector in the LSBs.
REQ-012 fifo_level  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow_count  output  8  number of events dropped, saturating.
REQ-014 report_sticky  output  N_REPORTS  OR of all masked reports seen since reset or the last clear.

Function
REQ-015 The timestamp counter SHALL increment by 1 on each cycle with run=1, hold while run=0, and wrap from 2^TS_WIDTH-1 to 0.
REQ-016 An event SHALL be generated in a cycle when run=1 and (report_in & report_mask) != 0; it carries the counter value of that cycle, before its increment.
REQ-017 report_in SHALL be ignored when run=0: no event is generated and report_sticky is not updated.
REQ-018 Event capture SHALL be level-based: a report high for k consecutive run cycles yields k events.
REQ-019 The FIFO SHALL be first-word-fall-through: out_valid=1 iff fifo_level>0, and out_data equals the oldest entry.
REQ-020 A pop SHALL occur when out_valid & out_ready; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 The minimum latency from the event cycle to out_valid=1 SHALL be 1 cycle, with the FIFO empty.
REQ-022 When the FIFO is full and a pop occurs in the same cycle as an event, the event SHALL be accepted and fifo_level remains DEPTH.
REQ-023 When the FIFO is full, no pop occurs and an event arrives, the event SHALL be dropped and overflow_count SHALL increment, saturating at 255.
REQ-024 An event and a pop on an empty FIFO SHALL NOT bypass: the event is stored and appears on the next cycle.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL equal the number of pushes minus the number of pops.
REQ-026 report_sticky SHALL OR in (report_in & report_mask) every run cycle.
REQ-027 A clear_stats pulse SHALL zero overflow_count and report_sticky; an increment or OR in the same cycle SHALL win, leaving 1 or the new bits.
REQ-028 clear_stats SHALL NOT affect the FIFO contents or the timestamp.

Reset
REQ-029 While reset=1, out_valid=0, fifo_level=0, overflow_count=0, report_sticky=0 and timestamp=0; reset dominates run and clear_stats.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries on the next clock edge.
REQ-031 The first run cycle after reset deasserts SHALL carry timestamp 0.

Verification
REQ-032 Reset, then run=1 for 3 cycles with report_in=0010 on the third, mask=1111, out_ready=1 -> one event, out_data={16'd2,4'b0010}, sticky=0010.
REQ-033 DEPTH=8, out_ready=0, 10 consecutive reporting run cycles -> fifo_level=8, overflow_count=2, and the drained timestamps are 0..7.
REQ-034 FIFO full, out_ready=1 and an event in the same cycle -> level stays 8, overflow_count unchanged, and the new entry is last in order.
REQ-035 mask=0001, report_in=1110 with run=1; then report_in=0001 with run=0 -> no events, sticky=0000.
REQ-036 Timestamp at 16'hFFFF, event this cycle and the next -> out_data timestamps are FFFF, then 0000.
REQ-037 With 5 entries queued, assert reset for 1 cycle -> next cycle out_valid=0, level=0, and the first new event has timestamp 0.

Source files
------------

// File: rtl/monitor_report_collector.sv
// Collects automaton report lines into timestamped events and buffers them in a
// first-word-fall-through FIFO, with drop counting and a sticky report summary.
module monitor_report_collector #(
  parameter int N_REPORTS = 4,
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic [N_REPORTS-1:0]            report_in,
  input  logic [N_REPORTS-1:0]            report_mask,
  input  logic                            clear_stats,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TS_WIDTH+N_REPORTS-1:0]   out_data,
  output logic [$clog2(DEPTH):0]          fifo_level,
  output logic [7:0]                      overflow_count,
  output logic [N_REPORTS-1:0]            report_sticky
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LVL_W   = ADDR_W + 1;
  localparam int ENTRY_W = TS_WIDTH + N_REPORTS;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [N_REPORTS-1:0] masked;
  logic                 evt;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 empty, full, pop, push, drop;
  logic [7:0]           ovf_q, ovf_d, ovf_base;
  logic [N_REPORTS-1:0] sticky_q, sticky_d;

  always_comb begin
    masked = report_in & report_mask;
    evt    = run & (|masked);
    empty  = (level_q == '0);
    full   = (level_q == FULL_LVL);
    pop    = ~empty & out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts an event
    // when the consumer is draining; an empty FIFO never forwards combinationally.
    push   = evt & (~full | pop);
    drop   = evt & full & ~pop;
  end

  always_comb begin
    ts_d     = run  ? ts_q + TS_WIDTH'(1) : ts_q;
    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Clear is applied first so a same-cycle drop or report still lands.
  always_comb begin
    ovf_base = clear_stats ? 8'd0 : ovf_q;
    ovf_d    = drop ? sat_inc8(ovf_base) : ovf_base;
    sticky_d = (clear_stats ? '0 : sticky_q) | (run ? masked : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      sticky_q <= '0;
    end else begin
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage is data only; validity comes entirely from the level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ts_q, masked};
    end
  end

  assign out_valid      = ~empty;
  assign out_data       = mem_q[rd_ptr_q];
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign report_sticky  = sticky_q;

endmodule

// File: tb/tb_monitor_report_collector.sv
// Directed bench for monitor_report_collector: each task drives a scenario and
// compares outputs against hand-computed values.
module tb_monitor_report_collector;

  localparam int NR  = 4;
  localparam int TSW = 16;
  localparam int DP  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [NR-1:0]   report_in;
  logic [NR-1:0]   report_mask;
  logic            clear_stats;
  logic            out_valid;
  logic            out_ready;
  logic [TSW+NR-1:0] out_data;
  logic [3:0]      fifo_level;
  logic [7:0]      overflow_count;
  logic [NR-1:0]   report_sticky;

  int errors = 0;
  int checks = 0;

  monitor_report_collector #(.N_REPORTS(NR), .TS_WIDTH(TSW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .run(run), .report_in(report_in),
    .report_mask(report_mask), .clear_stats(clear_stats), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
    .overflow_count(overflow_count), .report_sticky(report_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; report_in = '0; report_mask = '1;
    clear_stats = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; report_in = 4'b1111; report_mask = 4'b1111;
    clear_stats = 1'b1; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (overflow_count !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", overflow_count); end
    checks++; if (report_sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", report_sticky); end
    reset = 1'b0; run = 1'b0; report_in = '0; clear_stats = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b1; run = 1'b1; report_in = 4'b0000;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_noevt: got %b expected 0", out_valid); end
    report_in = 4'b0010;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL basic_nobypass_level: got %0d expected 1", fifo_level); end
    checks++; if (out_data !== {16'd2, 4'b0010}) begin errors++; $display("FAIL basic_data: got %h expected %h", out_data, {16'd2, 4'b0010}); end
    checks++; if (report_sticky !== 4'b0010) begin errors++; $display("FAIL basic_sticky: got %b expected 0010", report_sticky); end
    run = 1'b0; report_in = '0;
    tick();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL basic_pop: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b0; run = 1'b1; report_in = 4'b0001;
    repeat (10) tick();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
    checks++; if (overflow_count !== 8'd2) begin errors++; $display("FAIL ovf_count: got %0d expected 2", overflow_count); end
    repeat (300) tick();
    checks++; if (overflow_count !== 8'd255) begin errors++; $display("FAIL ovf_saturate: got %0d expected 255", overflow_count); end
    run = 1'b0; report_in = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== {16'(i), 4'b0001}) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, {16'(i), 4'b0001});
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_empty: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level); end
  endtask

  task automatic test_full_pop();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b0; run = 1'b1; report_in = 4'b0001;
    repeat (8) tick();
    out_ready = 1'b1; report_in = 4'b0100;
    tick();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpop_level: got %0d expected 8", fifo_level); end
    checks++; if (overflow_count !== 8'd0) begin errors++; $display("FAIL fullpop_ovf: got %0d expected 0", overflow_count); end
    run = 1'b0; report_in = '0;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (out_data !== {16'(i), 4'b0001}) begin errors++; $display("FAIL fullpop_order%0d: got %h expected %h", i, out_data, {16'(i), 4'b0001}); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== {16'd8, 4'b0100}) begin errors++; $display("FAIL fullpop_last: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, {16'd8, 4'b0100}); end
    tick();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL fullpop_empty: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_mask();
    do_reset();
    out_ready = 1'b0; report_mask = 4'b0001; run = 1'b1; report_in = 4'b1110;
    tick();
    run = 1'b0; report_in = 4'b0001;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL mask_noevt: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level); end
    checks++; if (report_sticky !== 4'b0000) begin errors++; $display("FAIL mask_sticky: got %b expected 0000", report_sticky); end
    run = 1'b1;
    tick();
    run = 1'b0; report_in = '0;
    checks++; if (out_data !== {16'd1, 4'b0001}) begin errors++; $display("FAIL mask_ts_hold: got %h expected %h", out_data, {16'd1, 4'b0001}); end
    checks++; if (report_sticky !== 4'b0001) begin errors++; $display("FAIL mask_sticky_set: got %b expected 0001", report_sticky); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b1; run = 1'b1; report_in = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fifo_level !== 4'd1 || out_data !== {16'(i), 4'b1000}) begin
        errors++; $display("FAIL b2b%0d: got lvl=%0d d=%h expected lvl=1 d=%h", i, fifo_level, out_data, {16'(i), 4'b1000});
      end
    end
    run = 1'b0; report_in = '0;
    tick();
  endtask

  task automatic test_clear();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b0; run = 1'b1; report_in = 4'b0001;
    repeat (9) tick();
    checks++; if (overflow_count !== 8'd1 || report_sticky !== 4'b0001) begin errors++; $display("FAIL clr_pre: got ovf=%0d st=%b expected ovf=1 st=0001", overflow_count, report_sticky); end
    run = 1'b0; clear_stats = 1'b1;
    tick();
    checks++; if (overflow_count !== 8'd0 || report_sticky !== 4'b0000) begin errors++; $display("FAIL clr_zero: got ovf=%0d st=%b expected ovf=0 st=0000", overflow_count, report_sticky); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL clr_fifo: got %0d expected 8", fifo_level); end
    run = 1'b1; report_in = 4'b0100;
    tick();
    checks++; if (overflow_count !== 8'd1 || report_sticky !== 4'b0100) begin errors++; $display("FAIL clr_win: got ovf=%0d st=%b expected ovf=1 st=0100", overflow_count, report_sticky); end
    run = 1'b0; report_in = '0; clear_stats = 1'b0;
    checks++; if (out_data !== {16'd0, 4'b0001}) begin errors++; $display("FAIL clr_head: got %h expected %h", out_data, {16'd0, 4'b0001}); end
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0; run = 1'b1; report_in = 4'b0010;
    tick();
    run = 1'b0; report_in = '0;
    checks++; if (out_data !== {16'd10, 4'b0010}) begin errors++; $display("FAIL clr_ts: got %h expected %h", out_data, {16'd10, 4'b0010}); end
  endtask

  task automatic test_wrap();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b0; run = 1'b1; report_in = 4'b0000;
    repeat (65535) @(posedge clk);
    #1;
    report_in = 4'b0001;
    tick(); tick();
    run = 1'b0; report_in = '0;
    checks++; if (fifo_level !== 4'd2 || out_data !== {16'hFFFF, 4'b0001}) begin errors++; $display("FAIL wrap_first: got lvl=%0d d=%h expected lvl=2 d=%h", fifo_level, out_data, {16'hFFFF, 4'b0001}); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== {16'h0000, 4'b0001}) begin errors++; $display("FAIL wrap_second: got %h expected %h", out_data, {16'h0000, 4'b0001}); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    report_mask = 4'b1111; out_ready = 1'b0; run = 1'b1; report_in = 4'b0001;
    repeat (5) tick();
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL rmid_pre: got %0d expected 5", fifo_level); end
    reset = 1'b1; run = 1'b0; report_in = '0;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL rmid_flush: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level); end
    run = 1'b1; report_in = 4'b0010;
    tick();
    run = 1'b0; report_in = '0;
    checks++; if (out_data !== {16'd0, 4'b0010}) begin errors++; $display("FAIL rmid_ts0: got %h expected %h", out_data, {16'd0, 4'b0010}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_mask();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
